// File: rtl/serializador_paridade.sv
// Parallel-to-serial feeder: shifts a word out MSB-first over a valid/ready
// handshake and appends one parity bit per frame.
module serializador_paridade #(
  parameter int N         = 8,
  parameter bit PAR_IMPAR = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         ready,
  output logic         out_bit,
  output logic         bit_valid,
  output logic         frame_end
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DESLOCA  = 2'd1,
    PARIDADE = 2'd2
  } estado_t;

  estado_t          state;
  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             accept;

  assign ready  = (state == OCIOSO) || (state == PARIDADE);
  assign accept = load && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OCIOSO;
      shreg <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
    end else begin
      unique case (state)
        OCIOSO, PARIDADE: begin
          // PARIDADE may take the next word in the same cycle: back-to-back frames
          if (accept) begin
            shreg <= data_in;
            cnt   <= '0;
            acc   <= ^data_in;
            state <= DESLOCA;
          end else begin
            state <= OCIOSO;
          end
        end
        DESLOCA: begin
          shreg <= {shreg[N-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= PARIDADE;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  // Outputs decode registered state only; no path from load/data_in.
  always_comb begin
    out_bit   = 1'b0;
    bit_valid = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      DESLOCA: begin
        out_bit   = shreg[N-1];
        bit_valid = 1'b1;
      end
      PARIDADE: begin
        out_bit   = acc ^ PAR_IMPAR;
        bit_valid = 1'b1;
        frame_end = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serializador_paridade.sv
// Directed bench for serializador_paridade: even and odd parity instances
// driven by the same stimulus.
module tb_serializador_paridade;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       ready, out_bit, bit_valid, frame_end;
  logic       ready_o, out_bit_o, bit_valid_o, frame_end_o;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  serializador_paridade #(.N(8), .PAR_IMPAR(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready), .out_bit(out_bit), .bit_valid(bit_valid), .frame_end(frame_end)
  );

  serializador_paridade #(.N(8), .PAR_IMPAR(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready_o), .out_bit(out_bit_o), .bit_valid(bit_valid_o), .frame_end(frame_end_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"},     ready,     1'b1);
    chk({tag, " out_bit"},   out_bit,   1'b0);
    chk({tag, " bit_valid"}, bit_valid, 1'b0);
    chk({tag, " frame_end"}, frame_end, 1'b0);
  endtask

  // Accepts w from idle and checks the full frame plus the return to idle.
  task automatic run_frame(input logic [7:0] w, input logic par, input string tag);
    logic det;
    det     = 1'b0;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s data%0d", tag, i), out_bit, w[7-i]);
      chk($sformatf("%s valid%0d", tag, i), bit_valid, 1'b1);
      chk($sformatf("%s fend%0d", tag, i), frame_end, 1'b0);
      chk($sformatf("%s ready%0d", tag, i), ready, 1'b0);
      det ^= out_bit;
      tick();
    end
    chk({tag, " parity"}, out_bit, par);
    chk({tag, " parity odd"}, out_bit_o, ~par);
    chk({tag, " par fend"}, frame_end, 1'b1);
    chk({tag, " par valid"}, bit_valid, 1'b1);
    chk({tag, " par ready"}, ready, 1'b1);
    det ^= out_bit;
    chk({tag, " detector"}, det, 1'b0);
    tick();
    chk_idle({tag, " after"});
  endtask

  initial begin
    logic [17:0] seq;
    logic [7:0]  w;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) begin
      chk_idle($sformatf("idle%0d", i));
      tick();
    end

    // 2, 3: single frames with known parity
    run_frame(8'b1011_0010, 1'b0, "b2");
    run_frame(8'h07, 1'b1, "h07");

    // 4: back-to-back frames, second accepted during PARIDADE
    seq     = {8'hFF, 1'b0, 8'h01, 1'b1};
    load    = 1'b1;
    data_in = 8'hFF;
    tick();
    data_in = 8'h01;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("b2b valid%0d", i), bit_valid, 1'b1);
      chk($sformatf("b2b bit%0d", i), out_bit, seq[17-i]);
      chk($sformatf("b2b fend%0d", i), frame_end, (i == 8) || (i == 17));
      tick();
      if (i == 8) load = 1'b0;
    end
    chk_idle("b2b after");

    // 5: reset after the 4th data bit aborts the frame
    w       = 8'hA5;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort data%0d", i), out_bit, w[7-i]);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_idle($sformatf("abort idle%0d", i));
      tick();
    end

    // 6: load during DESLOCA is ignored
    w       = 8'h81;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ign data%0d", i), out_bit, w[7-i]);
      chk($sformatf("ign valid%0d", i), bit_valid, 1'b1);
      if (i == 2) begin
        load    = 1'b1;
        data_in = 8'h3C;
      end
      tick();
      load = 1'b0;
    end
    chk("ign parity", out_bit, 1'b0);
    chk("ign par fend", frame_end, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_idle($sformatf("ign idle%0d", i));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
